// File: rtl/br_resolve_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_resolve_sched_pkg
// Description : Shared definitions for the branch-resolution scheduler.
//               It holds the default PC, offset and tag widths. It defines the
//               branch-request and resolved-result structs at those widths,
//               and a mispredict helper.
// Revision    : 1.0 - initial release
// ============================================================================
package br_resolve_sched_pkg;

    localparam int DEF_PC_WIDTH      = 32;
    localparam int DEF_BR_ADDR_WIDTH = 16;
    localparam int DEF_TAG_WIDTH     = 5;

    // PC-carrying fields number bit 0 as the MSB.
    typedef struct packed {
        logic [0:DEF_PC_WIDTH-1]      pc;
        logic [DEF_BR_ADDR_WIDTH-1:0] offset;
        logic [DEF_TAG_WIDTH-1:0]     tag;
        logic                         pred_taken;
        logic                         taken;
    } br_req_t;

    typedef struct packed {
        logic [0:DEF_PC_WIDTH-1]  target;
        logic [DEF_TAG_WIDTH-1:0] tag;
        logic                     taken;
        logic                     mispredict;
    } br_res_t;

    function automatic logic is_mispredict(input logic pred_taken, input logic taken);
        return pred_taken ^ taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : br_addr_gen
// Description : Branch target adder. It computes sum = pc + (sign-extended
//               word offset << 2) modulo 2^PC_WIDTH. The carry out is
//               discarded.
// Ports       : pc (in), offset (in, signed words), sum (out)
// Revision    : 1.0 - initial release
// ============================================================================
module br_addr_gen #(
    parameter int PC_WIDTH      = 32,
    parameter int BR_ADDR_WIDTH = 16
) (
    input  logic [0:PC_WIDTH-1]      pc,
    input  logic [BR_ADDR_WIDTH-1:0] offset,
    output logic [0:PC_WIDTH-1]      sum
);
    localparam int EXT_W = PC_WIDTH - BR_ADDR_WIDTH - 2;

    logic [0:PC_WIDTH-1] w_disp;

    assign w_disp = {{EXT_W{offset[BR_ADDR_WIDTH-1]}}, offset, 2'b00};
    assign sum    = pc + w_disp;

endmodule
`default_nettype wire

// File: rtl/br_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_req_fifo
// Description : Synchronous circular buffer with push/pop, full/empty, count
//               and a flush that empties it at the next edge. A push while
//               full or a pop while empty is ignored.
// Ports       : clk, rst, flush, push, pop, din, dout (head entry),
//               full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module br_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/br_resolve_sched.sv
`default_nettype none
// ============================================================================
// Module      : br_resolve_sched
// Description : Branch-resolution scheduler. It buffers resolved-condition
//               branch requests in order and shares one br_addr_gen across
//               them. It registers the target and mispredict flag and
//               presents each result on a valid/ready handshake.
// Ports       : clk, rst (sync, active-high), flush
//               req_valid/req_ready/req_pc/req_offset/req_tag/
//               req_pred_taken/req_taken    - request side
//               res_valid/res_ready/res_target/res_tag/res_taken/
//               res_mispredict              - result side
//               occupancy                   - buffered entries (excl. result)
//               stat_resolved/stat_mispredict - only with BR_SCHED_STATS_EN
// Options     : `define BR_SCHED_STATS_EN adds the 32-bit statistic counters
// Revision    : 1.0 - initial release
// ============================================================================
module br_resolve_sched
    import br_resolve_sched_pkg::*;
#(
    parameter int PC_WIDTH      = DEF_PC_WIDTH,
    parameter int BR_ADDR_WIDTH = DEF_BR_ADDR_WIDTH,
    parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [0:PC_WIDTH-1]      req_pc,
    input  logic [BR_ADDR_WIDTH-1:0] req_offset,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    input  logic                     req_pred_taken,
    input  logic                     req_taken,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [0:PC_WIDTH-1]      res_target,
    output logic [TAG_WIDTH-1:0]     res_tag,
    output logic                     res_taken,
    output logic                     res_mispredict,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef BR_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispredict
`endif
);
    // Buffer entry at this instance's widths.
    typedef struct packed {
        logic [0:PC_WIDTH-1]      pc;
        logic [BR_ADDR_WIDTH-1:0] offset;
        logic [TAG_WIDTH-1:0]     tag;
        logic                     pred_taken;
        logic                     taken;
    } entry_t;

    entry_t              w_wr_entry;
    entry_t              w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_load;
    logic [0:PC_WIDTH-1] w_sum;

    logic                 r_res_valid;
    logic [0:PC_WIDTH-1]  r_res_target;
    logic [TAG_WIDTH-1:0] r_res_tag;
    logic                 r_res_taken;
    logic                 r_res_mispredict;

    assign w_wr_entry = '{pc: req_pc, offset: req_offset, tag: req_tag,
                          pred_taken: req_pred_taken, taken: req_taken};

    // No full-bypass: a pop in the same cycle does not reopen a full buffer.
    assign req_ready = ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_load    = ~w_empty & (~r_res_valid | res_ready);

    br_req_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_load),
        .din   (w_wr_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (occupancy)
    );

    br_addr_gen #(
        .PC_WIDTH      (PC_WIDTH),
        .BR_ADDR_WIDTH (BR_ADDR_WIDTH)
    ) u_addr_gen (
        .pc     (w_head.pc),
        .offset (w_head.offset),
        .sum    (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_res_valid      <= 1'b0;
            r_res_target     <= '0;
            r_res_tag        <= '0;
            r_res_taken      <= 1'b0;
            r_res_mispredict <= 1'b0;
        end else if (w_load) begin
            r_res_valid      <= 1'b1;
            r_res_target     <= w_head.taken ? w_sum : w_head.pc;
            r_res_tag        <= w_head.tag;
            r_res_taken      <= w_head.taken;
            r_res_mispredict <= is_mispredict(w_head.pred_taken, w_head.taken);
        end else if (r_res_valid && res_ready) begin
            // The result drains. The fields keep their last value.
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid      = r_res_valid;
    assign res_target     = r_res_target;
    assign res_tag        = r_res_tag;
    assign res_taken      = r_res_taken;
    assign res_mispredict = r_res_mispredict;

`ifdef BR_SCHED_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;

    // Handshakes count even in a flush cycle. Only rst clears the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else if (r_res_valid && res_ready) begin
            r_stat_resolved <= r_stat_resolved + 32'd1;
            if (r_res_mispredict) r_stat_mispredict <= r_stat_mispredict + 32'd1;
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_br_resolve_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_resolve_sched
// Description : Self-checking bench for br_resolve_sched. A queue-based
//               reference model predicts every output each cycle. Literal
//               checks from hand-worked cases pin the model. Randomized
//               traffic with back-pressure, flush and reset follows.
// Options     : honours BR_SCHED_STATS_EN to exercise the statistic counters
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_resolve_sched;
    import br_resolve_sched_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [0:31] req_pc = '0;
    logic [15:0] req_offset = '0;
    logic [4:0]  req_tag = '0;
    logic        req_pred_taken = 1'b0;
    logic        req_taken = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [0:31] res_target;
    logic [4:0]  res_tag;
    logic        res_taken;
    logic        res_mispredict;
    logic [2:0]  occupancy;
`ifdef BR_SCHED_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    br_req_t     mq[$];
    logic        m_valid  = 1'b0;
    logic [31:0] m_target = '0;
    logic [4:0]  m_tag    = '0;
    logic        m_taken  = 1'b0;
    logic        m_misp   = 1'b0;
    logic [31:0] m_stat_res = '0;
    logic [31:0] m_stat_mis = '0;

    always #5 clk = ~clk;

    br_resolve_sched #(
        .PC_WIDTH      (32),
        .BR_ADDR_WIDTH (16),
        .TAG_WIDTH     (5),
        .DEPTH         (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .req_offset     (req_offset),
        .req_tag        (req_tag),
        .req_pred_taken (req_pred_taken),
        .req_taken      (req_taken),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_target     (res_target),
        .res_tag        (res_tag),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .occupancy      (occupancy)
`ifdef BR_SCHED_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The target is the branch PC plus the signed word offset times four, modulo 2^32.
    function automatic logic [31:0] target_of(input br_req_t r);
        int disp;
        disp = int'($signed(r.offset)) * 4;
        return r.taken ? 32'(r.pc + 32'(disp)) : 32'(r.pc);
    endfunction

    // Advance the model one clock, using the inputs now driven and the state before the edge.
    task automatic model_edge();
        br_req_t r;
        bit      hs;
        bit      accept;
        bit      do_load;
        hs      = m_valid && res_ready;
        accept  = req_valid && (mq.size() < DEPTH);
        do_load = (mq.size() > 0) && (!m_valid || res_ready);
        if (rst) begin
            m_stat_res = '0;
            m_stat_mis = '0;
        end else if (hs) begin
            m_stat_res = m_stat_res + 1;
            if (m_misp) m_stat_mis = m_stat_mis + 1;
        end
        if (rst || flush) begin
            mq.delete();
            m_valid = 0; m_target = '0; m_tag = '0; m_taken = 0; m_misp = 0;
        end else begin
            if (do_load) begin
                r = mq.pop_front();
                m_valid  = 1;
                m_target = target_of(r);
                m_tag    = r.tag;
                m_taken  = r.taken;
                m_misp   = (r.taken != r.pred_taken);
            end else if (hs) begin
                m_valid = 0;
            end
            if (accept) begin
                r.pc = req_pc; r.offset = req_offset; r.tag = req_tag;
                r.pred_taken = req_pred_taken; r.taken = req_taken;
                mq.push_back(r);
            end
        end
    endtask

    task automatic compare_all();
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("res_target", 64'(res_target), 64'(m_target));
        chk("res_tag", 64'(res_tag), 64'(m_tag));
        chk("res_taken", 64'(res_taken), 64'(m_taken));
        chk("res_mispredict", 64'(res_mispredict), 64'(m_misp));
`ifdef BR_SCHED_STATS_EN
        chk("stat_resolved", 64'(stat_resolved), 64'(m_stat_res));
        chk("stat_mispredict", 64'(stat_mispredict), 64'(m_stat_mis));
`endif
    endtask

    // Drive inputs (just after a falling edge), update the model, cross the
    // rising edge, then compare at the next falling edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [15:0] off,
                        input logic [4:0] tag, input bit pred, input bit tk,
                        input bit rr, input bit fl, input bit rs);
        req_valid = v; req_pc = pc; req_offset = off; req_tag = tag;
        req_pred_taken = pred; req_taken = tk;
        res_ready = rr; flush = fl; rst = rs;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rr);
        step(0, 32'h0, 16'h0, 5'd0, 0, 0, rr, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_occupancy", 64'(occupancy), 64'd0);

        // Single request, positive offset, mispredicted
        step(1, 32'h00400004, 16'h0003, 5'd5, 0, 1, 0, 0, 0);
        idle(0);
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_target", 64'(res_target), 64'h00400010);
        chk("t1_misp", 64'(res_mispredict), 64'd1);
        chk("t1_tag", 64'(res_tag), 64'd5);
        idle(1);

        // Negative offset, taken then not taken
        step(1, 32'h00400100, 16'hFFFF, 5'd6, 1, 1, 1, 0, 0);
        idle(1);
        chk("neg_target", 64'(res_target), 64'h004000FC);
        chk("neg_misp", 64'(res_mispredict), 64'd0);
        step(1, 32'h00400100, 16'hFFFF, 5'd7, 1, 0, 1, 0, 0);
        idle(1);
        chk("nt_target", 64'(res_target), 64'h00400100);

        // Address wrap
        step(1, 32'hFFFFFFF8, 16'h0004, 5'd8, 0, 1, 1, 0, 0);
        idle(1);
        chk("wrap_target", 64'(res_target), 64'h00000008);
        idle(1);

        // Back-pressure: five requests with res_ready held low
        for (int i = 0; i < 5; i++)
            step(1, 32'h1000 + 32'(i * 4), 16'(i), 5'(10 + i), 0, 0, 0, 0, 0);
        chk("bp_occupancy", 64'(occupancy), 64'd4);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_tag", 64'(res_tag), 64'd10);
        step(1, 32'h2000, 16'h0, 5'd15, 0, 0, 0, 0, 0);
        chk("bp_hold_tag", 64'(res_tag), 64'd10);
        chk("bp_hold_target", 64'(res_target), 64'h1000);
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 64'(res_valid), 64'd1);
            chk("drain_tag", 64'(res_tag), 64'(10 + i));
            idle(1);
        end
        chk("drain_done", 64'(res_valid), 64'd0);

        // Flush with three buffered and a result held
        for (int i = 0; i < 4; i++)
            step(1, 32'h3000, 16'h1, 5'(20 + i), 0, 1, 0, 0, 0);
        chk("pre_flush_occ", 64'(occupancy), 64'd3);
        step(1, 32'h4000, 16'h2, 5'd31, 0, 1, 1, 1, 0);
        chk("flush_valid", 64'(res_valid), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("post_flush_valid", 64'(res_valid), 64'd0);
        end

`ifdef BR_SCHED_STATS_EN
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(1, 32'h5000, 16'h1, 5'(i), 0, (i < 3), 1, 0, 0);
        idle(1);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("stat_resolved_10", 64'(stat_resolved), 64'd10);
        chk("stat_mispredict_3", 64'(stat_mispredict), 64'd3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("stat_resolved_rst", 64'(stat_resolved), 64'd0);
        chk("stat_mispredict_rst", 64'(stat_mispredict), 64'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit rr;
            rr = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, $urandom, 16'($urandom), 5'($urandom),
                 1'($urandom), 1'($urandom), rr,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
